// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU / M-extension unit.
package alu_pkg;

  // op[4] selects the M extension; op[3:0] is the base code, op[2:0] the funct3.
  localparam int unsigned OpW = 5;

  typedef struct packed {
    logic       is_m;
    logic [3:0] code;
  } op_t;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSlt   = 4'd5,
    AluSltu  = 4'd6,
    AluSll   = 4'd7,
    AluSrl   = 4'd8,
    AluSra   = 4'd9,
    AluCopyB = 4'd10,
    AluXxx   = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider on operand magnitudes with final sign fixup.
// Loaded by start; done is high for one cycle after XLEN steps, with result valid.
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q;
  logic            active_q;
  logic [XLEN-1:0] quot_q, rem_q, divisor_q;
  logic            neg_q_q, neg_r_q, rem_sel_q;

  logic [XLEN:0]   rem_shift, diff;
  logic [XLEN-1:0] mag_a, mag_b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor_q};
    mag_a     = (is_signed && a[XLEN-1]) ? -a : a;
    mag_b     = (is_signed && b[XLEN-1]) ? -b : b;
    done      = active_q && (cnt_q == '0);
    if (rem_sel_q) result = neg_r_q ? -rem_q : rem_q;
    else           result = neg_q_q ? -quot_q : quot_q;
  end

  // Load on start, iterate while the counter runs, retire once it expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (flush) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      cnt_q     <= CW'(XLEN);
      active_q  <= 1'b1;
      quot_q    <= mag_a;
      rem_q     <= '0;
      divisor_q <= mag_b;
      neg_q_q   <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r_q   <= is_signed && a[XLEN-1];
      rem_sel_q <= is_rem;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        // diff[XLEN] is the borrow: clear means the divisor fits.
        if (!diff[XLEN]) begin
          rem_q  <= diff[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q  <= rem_shift[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b0};
        end
        cnt_q <= cnt_q - 1'b1;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage integer ALU plus M extension with valid/ready handshake.
// Build option: ALU_MULDIV_FAST_MUL_EN selects a single-cycle multiplier;
// otherwise multiply is an XLEN-step shift-add in the MUL state.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OpW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  state_e          state_q;
  logic [XLEN-1:0] out_q;

  op_t             op_s;
  logic [2:0]      funct;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, exc_res, mag_a, mag_b;
  logic            is_div, div_signed, is_rem, b_zero, div_ovf, exc_div;
  logic            a_sgn, b_sgn, mul_neg_d, mul_hi_d;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_result;
  logic [XLEN-1:0] mul_out;

  assign op_s  = op;
  assign funct = op_s.code[2:0];

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out       = out_q;

  // Base ALU result, divide special cases and multiply operand preparation.
  always_comb begin
    shamt = b[SHW-1:0];
    case (op_s.code)
      AluAdd:   alu_res = a + b;
      AluSub:   alu_res = a - b;
      AluAnd:   alu_res = a & b;
      AluOr:    alu_res = a | b;
      AluXor:   alu_res = a ^ b;
      AluSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu:  alu_res = {{(XLEN-1){1'b0}}, a < b};
      AluSll:   alu_res = a << shamt;
      AluSrl:   alu_res = a >> shamt;
      AluSra:   alu_res = $unsigned($signed(a) >>> shamt);
      AluCopyB: alu_res = b;
      default:  alu_res = '0;
    endcase

    is_div     = funct[2];
    div_signed = !funct[0];
    is_rem     = funct[1];
    b_zero     = (b == '0);
    div_ovf    = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    exc_div    = is_div && (b_zero || div_ovf);
    if (b_zero) exc_res = is_rem ? a : '1;
    else        exc_res = is_rem ? '0 : a;

    // MUL is treated as signed x signed; its low half is sign-agnostic.
    a_sgn     = (funct[1:0] != 2'b11);
    b_sgn     = !funct[1];
    mul_hi_d  = (funct[1:0] != 2'b00);
    mag_a     = (a_sgn && a[XLEN-1]) ? -a : a;
    mag_b     = (b_sgn && b[XLEN-1]) ? -b : b;
    mul_neg_d = (a_sgn && a[XLEN-1]) ^ (b_sgn && b[XLEN-1]);
  end

  assign div_start = (state_q == StIdle) && in_valid && !flush && op_s.is_m && is_div
                     && !exc_div;

  alu_divider #(
    .XLEN (XLEN)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (div_start),
    .is_signed (div_signed),
    .is_rem    (is_rem),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .result    (div_result)
  );

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] mul_prod, mul_res;

  // Full-width product of magnitudes, sign restored, half selected.
  always_comb begin
    mul_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    mul_res  = mul_neg_d ? -mul_prod : mul_prod;
    mul_out  = mul_hi_d ? mul_res[2*XLEN-1:XLEN] : mul_res[XLEN-1:0];
  end
`else
  localparam int unsigned CW = SHW + 1;

  logic [CW-1:0]     mul_cnt_q;
  logic [2*XLEN-1:0] mul_acc_q, mul_mcand_q, mul_res;
  logic [XLEN-1:0]   mul_mplier_q;
  logic              mul_neg_q, mul_hi_q;

  // Sign restore and half selection on the accumulated magnitude product.
  always_comb begin
    mul_res = mul_neg_q ? -mul_acc_q : mul_acc_q;
    mul_out = mul_hi_q ? mul_res[2*XLEN-1:XLEN] : mul_res[XLEN-1:0];
  end
`endif

  // Control FSM and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
`ifndef ALU_MULDIV_FAST_MUL_EN
      mul_cnt_q    <= '0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_neg_q    <= 1'b0;
      mul_hi_q     <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= StIdle;
`ifndef ALU_MULDIV_FAST_MUL_EN
      mul_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (!op_s.is_m) begin
              out_q   <= alu_res;
              state_q <= StDone;
            end else if (is_div) begin
              if (exc_div) begin
                out_q   <= exc_res;
                state_q <= StDone;
              end else begin
                state_q <= StDiv;
              end
            end else begin
`ifdef ALU_MULDIV_FAST_MUL_EN
              out_q   <= mul_out;
              state_q <= StDone;
`else
              mul_acc_q    <= '0;
              mul_mcand_q  <= {{XLEN{1'b0}}, mag_a};
              mul_mplier_q <= mag_b;
              mul_neg_q    <= mul_neg_d;
              mul_hi_q     <= mul_hi_d;
              mul_cnt_q    <= CW'(XLEN);
              state_q      <= StMul;
`endif
            end
          end
        end
        StMul: begin
`ifdef ALU_MULDIV_FAST_MUL_EN
          state_q <= StIdle;
`else
          if (mul_cnt_q != '0) begin
            if (mul_mplier_q[0]) mul_acc_q <= mul_acc_q + mul_mcand_q;
            mul_mcand_q  <= mul_mcand_q << 1;
            mul_mplier_q <= mul_mplier_q >> 1;
            mul_cnt_q    <= mul_cnt_q - 1'b1;
          end else begin
            out_q   <= mul_out;
            state_q <= StDone;
          end
`endif
        end
        StDiv: begin
          if (div_done) begin
            out_q   <= div_result;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32): vector table, random ops against
// a reference model, and hand sequences for backpressure, flush and reset.
module tb_alu_muldiv;
  import alu_pkg::*;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [31:0] a, b, out;

  int n_pass = 0;
  int n_total = 0;

  alu_muldiv #(
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [4:0] bop(input alu_op_e c);
    return {1'b0, c};
  endfunction

  function automatic logic [4:0] mop(input md_op_e f);
    return {2'b10, f};
  endfunction

  // Reference result from the instruction semantics using wide integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int          sx, sy;
    logic [63:0] p;
    sx = x;
    sy = y;
    if (!o[4]) begin
      case (o[3:0])
        AluAdd:   return x + y;
        AluSub:   return x - y;
        AluAnd:   return x & y;
        AluOr:    return x | y;
        AluXor:   return x ^ y;
        AluSlt:   return (sx < sy) ? 32'd1 : 32'd0;
        AluSltu:  return (x < y) ? 32'd1 : 32'd0;
        AluSll:   return x << y[4:0];
        AluSrl:   return x >> y[4:0];
        AluSra:   return sx >>> y[4:0];
        AluCopyB: return y;
        default:  return 32'd0;
      endcase
    end
    case (o[2:0])
      MdMul:    begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      MdMulh:   begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      MdMulhsu: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
      MdMulhu:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      MdDiv:    begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        return sx / sy;
      end
      MdDivu:   return (y == 0) ? 32'hFFFFFFFF : x / y;
      MdRem:    begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return sx % sy;
      end
      default:  return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (!o[4]) return 1;
    if (!o[2]) return MulLat;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return DivLat;
  endfunction

  // Issue one op, scramble inputs after acceptance, time and check the result, drain it.
  task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat, input string nm);
    int n;
    @(negedge clk);
    chk({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 5'($urandom);
    a = $urandom;
    b = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " result"}, out, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [4:0]  ro;
    logic [31:0] ra, rb, held;
    int          k, seen;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    vecs.push_back('{bop(AluAdd), 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, "add ovf"});
    vecs.push_back('{bop(AluSra), 32'h80000000, 32'h24, 32'hF8000000, 1, "sra"});
    vecs.push_back('{bop(AluSub), 32'd5, 32'd7, 32'hFFFFFFFE, 1, "sub"});
    vecs.push_back('{bop(AluAnd), 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1, "and"});
    vecs.push_back('{bop(AluOr), 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 1, "or"});
    vecs.push_back('{bop(AluXor), 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, "xor"});
    vecs.push_back('{bop(AluSlt), 32'hFFFFFFFF, 32'd1, 32'd1, 1, "slt"});
    vecs.push_back('{bop(AluSltu), 32'hFFFFFFFF, 32'd1, 32'd0, 1, "sltu"});
    vecs.push_back('{bop(AluSll), 32'd1, 32'h21, 32'd2, 1, "sll"});
    vecs.push_back('{bop(AluSrl), 32'h80000000, 32'd4, 32'h08000000, 1, "srl"});
    vecs.push_back('{bop(AluCopyB), 32'd9, 32'hCAFE_BABE, 32'hCAFE_BABE, 1, "copyb"});
    vecs.push_back('{bop(AluXxx), 32'd9, 32'd9, 32'd0, 1, "xxx"});
    vecs.push_back('{5'h0F, 32'd9, 32'd9, 32'd0, 1, "undef"});
    vecs.push_back('{mop(MdMul), 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, MulLat, "mul"});
    vecs.push_back('{mop(MdMulh), 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, MulLat, "mulh"});
    vecs.push_back('{mop(MdMulhu), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulLat, "mulhu"});
    vecs.push_back('{mop(MdMulhsu), 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MulLat, "mulhsu"});
    vecs.push_back('{mop(MdDiv), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf"});
    vecs.push_back('{mop(MdRem), 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem ovf"});
    vecs.push_back('{mop(MdDivu), 32'd100, 32'd0, 32'hFFFFFFFF, 1, "divu /0"});
    vecs.push_back('{mop(MdRemu), 32'd100, 32'd0, 32'd100, 1, "remu /0"});
    vecs.push_back('{mop(MdDiv), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DivLat, "div -7/2"});
    vecs.push_back('{mop(MdRem), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DivLat, "rem -7/2"});
    vecs.push_back('{mop(MdRem), 32'd7, 32'hFFFFFFFE, 32'd1, DivLat, "rem 7/-2"});
    vecs.push_back('{mop(MdDivu), 32'd100, 32'd7, 32'd14, DivLat, "divu"});
    vecs.push_back('{mop(MdRemu), 32'd100, 32'd7, 32'd2, DivLat, "remu"});

    foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                          vecs[i].name);

    // Randomized ops against the reference model.
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 20);
      if (k < 12) ro = {1'b0, 4'(k)};
      else if (k == 12) ro = 5'h0D;
      else ro = {2'b10, 3'(k - 13)};
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run(ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb), "rand");
    end

    // Backpressure: result held while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1;
    op = bop(AluAdd);
    a = 32'd10;
    b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    held = out;
    chk("bp first", held, 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp out", out, 32'd30);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp drain in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp drain out_valid", {31'd0, out_valid}, 32'd0);

    // Flush 10 cycles into a divide.
    @(negedge clk);
    in_valid = 1'b1;
    op = mop(MdDiv);
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("flush no result", 32'(seen), 32'd0);
    run(bop(AluAdd), 32'd2, 32'd3, 32'd5, 1, "post-flush add");

    // Flush coinciding with in_valid in IDLE: not accepted.
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    op = bop(AluAdd);
    a = 32'd1;
    b = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush+valid busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("flush+valid out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1;
    op = mop(MdMul);
    a = 32'h12345678;
    b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid-rst out", out, 32'd0);
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    run(mop(MdMul), 32'd6, 32'd7, 32'd42, MulLat, "post-rst mul");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage arithmetic unit for the RISC-V core: all RV32I/RV64I integer ALU operations plus the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It has a valid/ready handshake so the pipeline can stall on multi-cycle operations.
- Base operations and the exceptional divides complete in one cycle.
- Divide is iterative.
- Multiply is iterative or single-cycle, selected by the macro under Configuration.
- It accepts one operation at a time and holds its result until the consumer takes it.

## Interface
- XLEN, 32: operand/result width. Power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width. Derived; not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  aborts any in-flight operation. Synchronous.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept. High only in IDLE and with rst low.
- op  in  5  op[4]=0: base ALU op, op[3:0] is the ALU op code. op[4]=1: M-extension op, op[2:0] is funct3.
- a, b  in  XLEN  operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  XLEN  registered result. Stable while out_valid is high and out_ready is low.
- busy  out  1  state is not IDLE.

## Operation
- Base ops are ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, COPY_B and XXX.
  - Shifts use b[SHW-1:0].
  - XXX yields 0.
  - An undefined code yields 0.
- States and transitions:
  - IDLE: an operation is accepted on in_valid & in_ready.
    - Base op or exceptional divide → DONE.
    - Multiply → MUL (iterative build) or DONE (fast build).
    - Other divide → DIV.
  - MUL: XLEN-step shift-add on 2·XLEN-bit magnitudes with sign correction per MULH/MULHSU/MULHU. Counter expiry → DONE.
  - DIV: XLEN-step restoring divide on magnitudes. Quotient sign = sign(a)^sign(b); remainder sign = sign(a). Counter expiry → DONE.
  - DONE: out_valid=1. out_ready → IDLE.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Exceptional divides always take one cycle:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = most negative, b = −1): DIV → a; REM → 0.
- Operands and op are captured at acceptance. Later input changes do not affect the result.
- Iteration counter is $clog2(XLEN)+1 bits wide and is loaded with XLEN on entry to MUL/DIV.
- flush is honoured in any state. Next state is IDLE, out_valid drops, and no result is produced. If flush and in_valid coincide in IDLE, the operation is not accepted.
- rst has priority over flush. On reset: state=IDLE, out_valid=0, out=0, counter=0, busy=0. in_ready is 0 while rst is high.

## Timing
- Acceptance at edge N. out_valid is then asserted after edge:
  - base op or exceptional divide: N+1;
  - divide: N+XLEN+1;
  - multiply: N+XLEN+1 (iterative) or N+1 (fast).
- In DONE with out_ready=1 at edge M, in_ready is high after edge M. There is no same-cycle accept-while-draining, so the throughput of base ops is one per 2 cycles.
- in_ready, busy and out_valid are decoded from registered state only. There are no combinational paths from in_valid/out_ready to in_ready.

## Configuration
- ALU_MULDIV_FAST_MUL_EN:
  - Defined: multiply uses a single-cycle 2·XLEN-bit product, registered into out. MUL state is unused, and multiply latency is 1.
  - Undefined: iterative shift-add in the MUL state, no hardware multiplier inferred, multiply latency XLEN+1.
  - Divide, handshake and flush behaviour are identical in both builds.

## Structure
- Package alu_pkg holds:
  - the 4-bit base op codes;
  - the M-extension funct3 codes;
  - the 5-bit op layout;
  - the state enum (IDLE, MUL, DIV, DONE).
- Sub-module alu_divider holds the restoring-divide datapath: start, counter, quotient/remainder registers, done, and the sign fixup. The top holds the FSM, base ALU, multiplier and output register.

## Test plan
- ADD a=0x7FFFFFFF b=1 accepted at N → out=0x80000000, out_valid after N+1. SRA a=0x80000000 b=0x24 → 0xF8000000 (shift by 4).
- MUL a=−2 b=3 → 0xFFFFFFFA. MULH of the same operands → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Latency is 33 cycles without the macro and 1 with it.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both at latency 1. DIVU 100/0 → 0xFFFFFFFF. REMU 100/0 → 100. DIV −7/2 → −3 and REM → −1, latency 33.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out stays constant, in_ready=0, busy=1. out_ready=1 → in_ready high the next cycle.
- flush 10 cycles into a DIV → out_valid never asserts and in_ready=1 next cycle. A following ADD 2+3 → 5.
- rst asserted mid-MUL → after release, out_valid=0, out=0 and busy=0, and a new op is accepted and computes correctly.
